// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB stage and a one-entry
// MDU result buffer; a starved MDU write eventually stalls the pipeline.
module wb_port_arbiter #(
  parameter int FORCE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_regwr,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [2:0] LIM = 3'(FORCE_LIMIT);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_rd;
  logic [31:0] r_data;
  logic [2:0]  r_wait;
  logic [15:0] r_stall_cnt;

  logic        w_pipe_act;
  logic [2:0]  w_wait_inc;
  logic [2:0]  w_wait_nxt;
  logic        w_load;
  logic        w_cnt_inc;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  assign w_pipe_act = wb_regwr && (wb_rd != 5'd0);
  assign w_wait_inc = r_wait + 3'd1;

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_wait_nxt = r_wait;
    w_cnt_inc  = 1'b0;
    w_we       = 1'b0;
    w_addr     = 5'd0;
    w_data     = 32'd0;
    unique case (r_state)
      EMPTY: begin
        if (w_pipe_act) begin
          w_we   = 1'b1;
          w_addr = wb_rd;
          w_data = wb_data;
        end
        if (mdu_valid && (mdu_rd != 5'd0)) begin
          w_load     = 1'b1;
          w_wait_nxt = 3'd0;
          w_next     = PEND;
        end
      end
      PEND: begin
        if (!w_pipe_act) begin
          w_we   = 1'b1;
          w_addr = r_rd;
          w_data = r_data;
          w_next = EMPTY;
        end else begin
          w_we   = 1'b1;
          w_addr = wb_rd;
          w_data = wb_data;
          // younger pipeline write to same rd supersedes the buffer
          if (wb_rd == r_rd) begin
            w_next = EMPTY;
          end else begin
            w_wait_nxt = w_wait_inc;
            if (w_wait_inc == LIM) begin
              w_next = FORCE;
            end
          end
        end
      end
      FORCE: begin
        w_we      = 1'b1;
        w_addr    = r_rd;
        w_data    = r_data;
        w_cnt_inc = 1'b1;
        w_next    = EMPTY;
      end
      default: begin
        w_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_rd        <= 5'd0;
      r_data      <= 32'd0;
      r_wait      <= 3'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_load) begin
        r_rd   <= mdu_rd;
        r_data <= mdu_data;
      end
      if (w_cnt_inc && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  // the WB-stage path is combinational, so mask it while in reset
  assign rf_we      = w_we & rst;
  assign rf_waddr   = rst ? w_addr : 5'd0;
  assign rf_wdata   = rst ? w_data : 32'd0;
  assign mdu_ready  = (r_state == EMPTY);
  assign pipe_stall = (r_state == FORCE);
  assign pend_valid = (r_state != EMPTY);
  assign pend_rd    = pend_valid ? r_rd : 5'd0;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, reset sequence,
// then random traffic against a pending-write reference model.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        wb_regwr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [15:0] stall_cnt;

  int n_checks;
  int n_fail;

  wb_port_arbiter #(.FORCE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_regwr  (wb_regwr),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mdu_valid (mdu_valid),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pipe_stall(pipe_stall),
    .pend_valid(pend_valid),
    .pend_rd   (pend_rd),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_pv;
    logic [4:0]  e_prd;
    logic        e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // reference model: a pending MDU write plus how many cycles it has lost
  bit          m_has;
  bit          m_force;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_lost;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_has = 0; m_force = 0; m_rd = 0; m_data = 0; m_lost = 0; m_cnt = 0;
  endtask

  task automatic model_check(input string tag);
    bit          pipe;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    pipe = wb_regwr && (wb_rd != 0);
    we = 0; a = 0; d = 0;
    if (m_force || (m_has && !pipe)) begin
      we = 1; a = m_rd; d = m_data;
    end else if (pipe) begin
      we = 1; a = wb_rd; d = wb_data;
    end
    chk({tag, " rf_we"}, 32'(rf_we), 32'(we));
    chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, " rf_wdata"}, rf_wdata, d);
    chk({tag, " pipe_stall"}, 32'(pipe_stall), 32'(m_force));
    chk({tag, " pend_valid"}, 32'(pend_valid), 32'(m_has));
    chk({tag, " pend_rd"}, 32'(pend_rd), m_has ? 32'(m_rd) : 32'd0);
    chk({tag, " mdu_ready"}, 32'(mdu_ready), 32'(!m_has));
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic model_commit();
    bit pipe;
    pipe = wb_regwr && (wb_rd != 0);
    if (m_force) begin
      m_has = 0; m_force = 0;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_has) begin
      if (!pipe || wb_rd == m_rd) begin
        m_has = 0;
      end else begin
        m_lost++;
        if (m_lost == LIMIT) m_force = 1;
      end
    end else if (mdu_valid && mdu_rd != 0) begin
      m_has = 1; m_rd = mdu_rd; m_data = mdu_data; m_lost = 0;
    end
  endtask

  task automatic idle_inputs();
    wb_regwr = 0; wb_rd = 0; wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  task automatic addv(input logic wr, input logic [4:0] wrd,
                      input logic [31:0] wdat, input logic mv,
                      input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic e_we, input logic [4:0] e_addr,
                      input logic [31:0] e_data, input logic e_stall,
                      input logic e_pv, input logic [4:0] e_prd,
                      input logic e_rdy, input logic [15:0] e_cnt);
    vec_t v;
    v.wr = wr; v.wrd = wrd; v.wdat = wdat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    v.e_stall = e_stall; v.e_pv = e_pv; v.e_prd = e_prd;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    string tag;
    n_checks = 0;
    n_fail = 0;
    model_reset();
    idle_inputs();
    rst = 0;

    //   wr rd  wdata         mv rd  mdata         we ad wdata         st pv prd rdy cnt
    addv(0, 0,  32'h0,        1, 5,  32'hA5A5A5A5, 0, 0, 32'h0,        0, 0, 0,  1, 0);
    addv(0, 0,  32'h0,        0, 0,  32'h0,        1, 5, 32'hA5A5A5A5, 0, 1, 5,  0, 0);
    addv(0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 32'h0,        0, 0, 0,  1, 0);
    addv(0, 0,  32'h0,        1, 7,  32'h77,       0, 0, 32'h0,        0, 0, 0,  1, 0);
    addv(1, 3,  32'h33,       0, 0,  32'h0,        1, 3, 32'h33,       0, 1, 7,  0, 0);
    addv(1, 4,  32'h44,       0, 0,  32'h0,        1, 4, 32'h44,       0, 1, 7,  0, 0);
    addv(1, 6,  32'h66,       0, 0,  32'h0,        1, 6, 32'h66,       0, 1, 7,  0, 0);
    addv(1, 8,  32'h88,       0, 0,  32'h0,        1, 8, 32'h88,       0, 1, 7,  0, 0);
    addv(1, 10, 32'hAA,       0, 0,  32'h0,        1, 7, 32'h77,       1, 1, 7,  0, 0);
    addv(1, 10, 32'hAA,       1, 9,  32'h99,       1, 10, 32'hAA,      0, 0, 0,  1, 1);
    addv(1, 9,  32'h11,       0, 0,  32'h0,        1, 9, 32'h11,       0, 1, 9,  0, 1);
    addv(0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 32'h0,        0, 0, 0,  1, 1);
    addv(1, 0,  32'h55,       1, 0,  32'hDEAD,     0, 0, 32'h0,        0, 0, 0,  1, 1);
    addv(0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 32'h0,        0, 0, 0,  1, 1);

    // reset state, with a live pipeline write that must be masked
    #2;
    wb_regwr = 1; wb_rd = 5'd3; wb_data = 32'h1234;
    #1;
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset mdu_ready", 32'(mdu_ready), 32'd1);
    chk("reset pend_valid", 32'(pend_valid), 32'd0);
    chk("reset pipe_stall", 32'(pipe_stall), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    foreach (vecs[i]) begin
      wb_regwr = vecs[i].wr; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdat;
      mdu_valid = vecs[i].mv; mdu_rd = vecs[i].mrd;
      mdu_data = vecs[i].mdat;
      #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, " rf_we"}, 32'(rf_we), 32'(vecs[i].e_we));
      chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(vecs[i].e_addr));
      chk({tag, " rf_wdata"}, rf_wdata, vecs[i].e_data);
      chk({tag, " pipe_stall"}, 32'(pipe_stall), 32'(vecs[i].e_stall));
      chk({tag, " pend_valid"}, 32'(pend_valid), 32'(vecs[i].e_pv));
      chk({tag, " pend_rd"}, 32'(pend_rd), 32'(vecs[i].e_prd));
      chk({tag, " mdu_ready"}, 32'(mdu_ready), 32'(vecs[i].e_rdy));
      chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(vecs[i].e_cnt));
      model_commit();
      @(posedge clk);
      @(negedge clk);
    end
    idle_inputs();

    // reset while an entry for r12 is pending
    mdu_valid = 1; mdu_rd = 5'd12; mdu_data = 32'hC0C0;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rst12 pend before", 32'(pend_valid), 32'd1);
    rst = 0;
    #1;
    chk("rst12 pend_valid", 32'(pend_valid), 32'd0);
    chk("rst12 rf_we", 32'(rf_we), 32'd0);
    chk("rst12 mdu_ready", 32'(mdu_ready), 32'd1);
    @(negedge clk);
    rst = 1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rst12 no write", 32'(rf_we && rf_waddr == 5'd12), 32'd0);
      @(negedge clk);
    end

    // randomized traffic with small rd range to provoke collisions
    for (int c = 0; c < 3000; c++) begin
      wb_regwr = ($urandom_range(0, 9) < 7);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      mdu_valid = $urandom_range(0, 1);
      mdu_rd = 5'($urandom_range(0, 7));
      mdu_data = $urandom;
      #1;
      model_check("rnd");
      model_commit();
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter FORCE_LIMIT, default 4, meaning the number of consecutive lost cycles before a pending MDU write forces a pipeline stall (legal 1..7).
REQ-002 The block SHALL have port clk, input, 1, the clock; reset rst, asynchronous, active-low.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port wb_regwr, input, 1, pipeline WB-stage write enable.
REQ-005 The block SHALL have port wb_rd, input, 5, pipeline WB-stage destination register.
REQ-006 The block SHALL have port wb_data, input, 32, pipeline WB-stage write data.
REQ-007 The block SHALL have port mdu_valid, input, 1, multi-cycle multiply/divide unit result valid.
REQ-008 The block SHALL have port mdu_rd, input, 5, MDU destination register.
REQ-009 The block SHALL have port mdu_data, input, 32, MDU result data.
REQ-010 The block SHALL have port mdu_ready, output, 1, buffer can accept an MDU result.
REQ-011 The block SHALL have ports rf_we (1), rf_waddr (5), rf_wdata (32), outputs, the single register-file write port.
REQ-012 The block SHALL have port pipe_stall, output, 1, pipeline must hold its WB stage this cycle.
REQ-013 The block SHALL have ports pend_valid (1), pend_rd (5), outputs, buffered MDU write visible to the hazard unit.
REQ-014 The block SHALL have port stall_cnt, output, 16, count of forced stalls.

Function
REQ-015 The block SHALL hold a one-entry buffer (rd, data) and a state machine with states EMPTY, PEND, FORCE, plus a 3-bit wait counter.
REQ-016 A pipeline write SHALL be active only when wb_regwr=1 and wb_rd!=0; an active pipeline write not in FORCE drives rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data in the same cycle (combinational, zero latency).
REQ-017 mdu_ready SHALL be 1 exactly in EMPTY; MDU transfer occurs on a clk edge with mdu_valid=1 and mdu_ready=1.
REQ-018 EMPTY: transfer with mdu_rd!=0 SHALL load the buffer, clear the wait counter, go to PEND; transfer with mdu_rd=0 SHALL be consumed and discarded, stay EMPTY.
REQ-019 PEND, no active pipeline write: rf_we=1, rf_waddr/rf_wdata from buffer; next state EMPTY.
REQ-020 PEND, active pipeline write with wb_rd equal to buffered rd: pipeline wins, buffer entry SHALL be dropped (younger write supersedes); next state EMPTY.
REQ-021 PEND, active pipeline write to a different rd: pipeline wins, wait counter increments; when the incremented value equals FORCE_LIMIT, next state FORCE.
REQ-022 FORCE: pipe_stall=1, buffer drives the write port, pipeline write suppressed (pipeline re-presents it next cycle), stall_cnt increments (saturating at 16'hFFFF); next state EMPTY.
REQ-023 pipe_stall SHALL be 0 in every state except FORCE.
REQ-024 pend_valid SHALL be 1 in PEND and FORCE, pend_rd = buffered rd; otherwise pend_valid=0, pend_rd=0.
REQ-025 When no source writes, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-026 At most one write SHALL occur on the port per cycle; no accepted nonzero-rd MDU result is lost except by REQ-020.

Reset
REQ-027 While rst=0: state EMPTY, buffer 0, wait counter 0, stall_cnt 0, rf_we=0, pipe_stall=0, pend_valid=0, mdu_ready=1, all other outputs 0.
REQ-028 Reset asserted in PEND or FORCE SHALL discard the buffered entry without writing it.

Verification
REQ-029 MDU rd=5 data=0xA5A5A5A5 accepted, wb_regwr=0 next cycle -> rf_we=1, waddr=5, wdata=0xA5A5A5A5 that cycle; mdu_ready=1 the cycle after.
REQ-030 MDU rd=7 buffered, pipeline writes rd=3,4,6,8 on four consecutive cycles -> those four writes pass, fifth cycle pipe_stall=1, write rd=7, stall_cnt=1.
REQ-031 MDU rd=9 buffered, pipeline writes rd=9 data=0x11 -> rf writes 0x11 to r9, pend_valid=0 next cycle, buffer never written.
REQ-032 MDU rd=0 offered -> accepted, pend_valid stays 0, no rf write; pipeline rd=0 with wb_regwr=1 -> rf_we=0.
REQ-033 rst pulled low while in PEND (rd=12) -> pend_valid=0, rf_we=0 immediately; after release no write to r12 occurs.
